dispatch_packer: RTL and testbench

- Dispatch-side feeder for the 4-in/1-out issue queue. Accepts one renamed uop per cycle from rename and buffers it in a circular FIFO.
- Emits 4-wide dispatch bundles onto the queue's four instruction inputs and its write enable.
- Keeps buffered uops current: applies writeback wakeup (4 tags/cycle) and branch-kill while they wait.

---
 rtl/dispatch_packer_pkg.sv | 53 +++++
 rtl/dispatch_packer_if.sv | 37 +++
 rtl/packer_entry_update.sv | 57 +++++
 rtl/dispatch_packer.sv | 145 ++++++++++++++
 tb/tb_dispatch_packer.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dispatch_packer_pkg.sv
// Shared uop layout helpers for the dispatch packer, issue queue and slots.
// Fields MSB..LSB: {uop, brm, tag, prd, pr2, pr1, val, p2, p1}.
package dispatch_packer_pkg;

    localparam int UOP_W = 7;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_FILL,
        ST_READY
    } pack_state_t;

    function automatic int off_p1();
        return 0;
    endfunction

    function automatic int off_p2();
        return 1;
    endfunction

    function automatic int off_val();
        return 2;
    endfunction

    function automatic int off_pr1();
        return 3;
    endfunction

    function automatic int off_pr2(int wreg);
        return 3 + wreg;
    endfunction

    function automatic int off_prd(int wreg);
        return 3 + 2 * wreg;
    endfunction

    function automatic int off_tag(int wreg);
        return 3 + 3 * wreg;
    endfunction

    function automatic int off_brm(int wreg, int wtag);
        return 3 + 3 * wreg + wtag;
    endfunction

    function automatic int off_uop(int wreg, int wtag, int wbrm);
        return 3 + 3 * wreg + wtag + wbrm;
    endfunction

    function automatic int uop_width(int wreg, int wtag, int wbrm);
        return UOP_W + wbrm + wtag + 3 * wreg + 3;
    endfunction

endpackage

// File: rtl/dispatch_packer_if.sv
// Rename-side push, writeback/kill broadcast and issue-queue bundle signals.
interface dispatch_packer_if
    import dispatch_packer_pkg::*;
#(
    parameter int WIDTH_REG = 3,
    parameter int WIDTH_TAG = 3,
    parameter int WIDTH_BRM = 3,
    parameter int WIDTH     = uop_width(WIDTH_REG, WIDTH_TAG, WIDTH_BRM),
    parameter int DEPTH     = 8
) ();

    logic [WIDTH-1:0]         i_inst;
    logic                     i_valid;
    logic                     o_ready;
    logic [4*WIDTH_REG-1:0]   i_wdest4x;
    logic [WIDTH_BRM-1:0]     i_BrKill;
    logic                     i_qready;
    logic [WIDTH-1:0]         o_inst1;
    logic [WIDTH-1:0]         o_inst2;
    logic [WIDTH-1:0]         o_inst3;
    logic [WIDTH-1:0]         o_inst4;
    logic                     o_en;
    logic [$clog2(DEPTH):0]   o_count;

    modport master (
        output i_inst, i_valid, i_wdest4x, i_BrKill, i_qready,
        input  o_ready, o_inst1, o_inst2, o_inst3, o_inst4,
        input  o_en, o_count
    );

    modport slave (
        input  i_inst, i_valid, i_wdest4x, i_BrKill, i_qready,
        output o_ready, o_inst1, o_inst2, o_inst3, o_inst4,
        output o_en, o_count
    );

endinterface

// File: rtl/packer_entry_update.sv
// Applies the 4-lane writeback wakeup and branch kill to one uop.
module packer_entry_update
    import dispatch_packer_pkg::*;
#(
    parameter int WIDTH_REG = 3,
    parameter int WIDTH_TAG = 3,
    parameter int WIDTH_BRM = 3,
    parameter int WIDTH     = uop_width(WIDTH_REG, WIDTH_TAG, WIDTH_BRM)
) (
    input  logic [WIDTH-1:0]       uop,
    input  logic [4*WIDTH_REG-1:0] wdest4x,
    input  logic [WIDTH_BRM-1:0]   br_kill,
    output logic [WIDTH-1:0]       upd
);

    localparam int O_P1  = off_p1();
    localparam int O_P2  = off_p2();
    localparam int O_VAL = off_val();
    localparam int O_PR1 = off_pr1();
    localparam int O_PR2 = off_pr2(WIDTH_REG);
    localparam int O_BRM = off_brm(WIDTH_REG, WIDTH_TAG);

    logic [WIDTH_REG-1:0] pr1;
    logic [WIDTH_REG-1:0] pr2;
    logic [WIDTH_BRM-1:0] brm;
    logic                 hit1;
    logic                 hit2;

    assign pr1 = uop[O_PR1 +: WIDTH_REG];
    assign pr2 = uop[O_PR2 +: WIDTH_REG];
    assign brm = uop[O_BRM +: WIDTH_BRM];

    // A zero lane means no write, so it can never wake a source.
    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        for (int l = 0; l < 4; l++) begin
            if (wdest4x[l*WIDTH_REG +: WIDTH_REG] != '0) begin
                if (wdest4x[l*WIDTH_REG +: WIDTH_REG] == pr1)
                    hit1 = 1'b1;
                if (wdest4x[l*WIDTH_REG +: WIDTH_REG] == pr2)
                    hit2 = 1'b1;
            end
        end
    end

    always_comb begin
        upd = uop;
        if (hit1)
            upd[O_P1] = 1'b1;
        if (hit2)
            upd[O_P2] = 1'b1;
        if ((brm & br_kill) != '0)
            upd[O_VAL] = 1'b0;
    end

endmodule

// File: rtl/dispatch_packer.sv
// Circular uop FIFO that packs renamed uops into 4-wide issue bundles,
// flushing a partial bundle after TIMEOUT idle cycles.
module dispatch_packer
    import dispatch_packer_pkg::*;
#(
    parameter int WIDTH_REG = 3,
    parameter int WIDTH_TAG = 3,
    parameter int WIDTH_BRM = 3,
    parameter int WIDTH     = uop_width(WIDTH_REG, WIDTH_TAG, WIDTH_BRM),
    parameter int DEPTH     = 8,
    parameter int TIMEOUT   = 4
) (
    input  logic          i_clk,
    input  logic          i_rst,
    dispatch_packer_if.slave dp
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0] FULL   = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] BUNDLE = CNT_W'(4);
    localparam logic [TMR_W-1:0] TMAX   = TMR_W'(TIMEOUT);

    logic [WIDTH-1:0] mem      [DEPTH];
    logic [WIDTH-1:0] ent_in   [DEPTH];
    logic [WIDTH-1:0] ent_upd  [DEPTH];
    logic [WIDTH-1:0] slot_in  [4];
    logic [WIDTH-1:0] slot_out [4];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] pop_n;
    logic [TMR_W-1:0] timer;
    logic [TMR_W-1:0] tmr_next;
    pack_state_t      state;
    pack_state_t      state_next;

    logic ready;
    logic push;
    logic en;
    logic pop;

    // Readiness uses the pre-pop count: a full FIFO refuses even while popping.
    assign ready = count < FULL;
    assign push  = dp.i_valid & ready;
    assign en    = state == ST_READY;
    assign pop   = en & dp.i_qready;

    assign pop_n    = !pop ? '0 : (count < BUNDLE) ? count : BUNDLE;
    assign cnt_next = count + CNT_W'(push) - pop_n;

    always_comb begin
        tmr_next = timer;
        if (push | pop)
            tmr_next = '0;
        else if (count != '0 && count < BUNDLE && timer < TMAX)
            tmr_next = timer + TMR_W'(1);
    end

    always_comb begin
        state_next = ST_FILL;
        if (cnt_next == '0)
            state_next = ST_EMPTY;
        else if (cnt_next >= BUNDLE || tmr_next == TMAX)
            state_next = ST_READY;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            timer <= '0;
            state <= ST_EMPTY;
        end else begin
            head  <= head + pop_n[PTR_W-1:0];
            tail  <= tail + PTR_W'(push);
            count <= cnt_next;
            timer <= tmr_next;
            state <= state_next;
        end
    end

    // The incoming uop shares its slot's updater so it gets same-cycle wakeup.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_in[i] = mem[i];
            if (push && tail == PTR_W'(i))
                ent_in[i] = dp.i_inst;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_ent
        packer_entry_update #(
            .WIDTH_REG (WIDTH_REG),
            .WIDTH_TAG (WIDTH_TAG),
            .WIDTH_BRM (WIDTH_BRM),
            .WIDTH     (WIDTH)
        ) u_upd (
            .uop     (ent_in[g]),
            .wdest4x (dp.i_wdest4x),
            .br_kill (dp.i_BrKill),
            .upd     (ent_upd[g])
        );
    end

    always_ff @(posedge i_clk) begin
        mem <= ent_upd;
    end

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            slot_in[k] = '0;
            if (CNT_W'(k) < count)
                slot_in[k] = mem[head + PTR_W'(k)];
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_slot
        packer_entry_update #(
            .WIDTH_REG (WIDTH_REG),
            .WIDTH_TAG (WIDTH_TAG),
            .WIDTH_BRM (WIDTH_BRM),
            .WIDTH     (WIDTH)
        ) u_upd (
            .uop     (slot_in[g]),
            .wdest4x (dp.i_wdest4x),
            .br_kill (dp.i_BrKill),
            .upd     (slot_out[g])
        );
    end

    assign dp.o_inst1 = slot_out[0];
    assign dp.o_inst2 = slot_out[1];
    assign dp.o_inst3 = slot_out[2];
    assign dp.o_inst4 = slot_out[3];
    assign dp.o_en    = en;
    assign dp.o_ready = ready;
    assign dp.o_count = count;

endmodule

// File: tb/tb_dispatch_packer.sv
// Bench for dispatch_packer: vector table, corner sequences, random vs queue model.
module tb_dispatch_packer;

    localparam int W       = 7 + 3 + 3 + 3 * 3 + 3;
    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 4;

    typedef struct {
        logic         v;
        logic [W-1:0] inst;
        logic         qr;
        logic         en;
        int           cnt;
        logic [W-1:0] i1;
        logic [W-1:0] i4;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    logic [W-1:0] mq [$];
    int           mt = 0;

    logic         obs_en;
    logic         obs_ready;
    int           obs_cnt;
    logic [W-1:0] obs_inst [4];

    always #5 clk = ~clk;

    dispatch_packer_if bus ();

    dispatch_packer dut (
        .i_clk (clk),
        .i_rst (rst),
        .dp    (bus)
    );

    function automatic logic [W-1:0] mk(
        input logic [6:0] op, input logic [2:0] brm, input logic [2:0] tag,
        input logic [2:0] prd, input logic [2:0] pr2, input logic [2:0] pr1,
        input logic v, input logic p2, input logic p1);
        return {op, brm, tag, prd, pr2, pr1, v, p2, p1};
    endfunction

    function automatic logic [W-1:0] pu(input int i);
        return mk(7'(i), 3'd0, 3'(i), 3'(i), 3'd0, 3'd0, 1'b1, 1'b0, 1'b0);
    endfunction

    // Reference wakeup/kill straight from the field definitions.
    function automatic logic [W-1:0] mupd(input logic [W-1:0] u,
                                         input logic [11:0] wd,
                                         input logic [2:0] kill);
        logic [W-1:0] r;
        logic [2:0]   t;
        r = u;
        for (int l = 0; l < 4; l++) begin
            t = wd[l*3 +: 3];
            if (t != 0 && t == u[5:3]) r[0] = 1'b1;
            if (t != 0 && t == u[8:6]) r[1] = 1'b1;
        end
        if ((u[17:15] & kill) != 0) r[2] = 1'b0;
        return r;
    endfunction

    function automatic vec_t row(input logic v, input logic [W-1:0] inst,
                                 input logic qr, input logic en, input int cnt,
                                 input logic [W-1:0] i1, input logic [W-1:0] i4);
        vec_t r;
        r.v = v; r.inst = inst; r.qr = qr;
        r.en = en; r.cnt = cnt; r.i1 = i1; r.i4 = i4;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step(input logic v, input logic [W-1:0] inst,
                        input logic [11:0] wd, input logic [2:0] kill,
                        input logic qr);
        int           n;
        logic         en;
        logic         pop;
        logic         push;
        logic [W-1:0] e;
        rst           = 1'b0;
        bus.i_valid   = v;
        bus.i_inst    = inst;
        bus.i_wdest4x = wd;
        bus.i_BrKill  = kill;
        bus.i_qready  = qr;
        @(negedge clk);
        obs_en    = bus.o_en;
        obs_ready = bus.o_ready;
        obs_cnt   = int'(bus.o_count);
        obs_inst[0] = bus.o_inst1;
        obs_inst[1] = bus.o_inst2;
        obs_inst[2] = bus.o_inst3;
        obs_inst[3] = bus.o_inst4;
        n  = mq.size();
        en = (n >= 4) || (n > 0 && mt == TIMEOUT);
        chk("mdl_count", 32'(obs_cnt), 32'(n));
        chk("mdl_en", 32'(obs_en), 32'(en));
        chk("mdl_ready", 32'(obs_ready), 32'(n < DEPTH));
        for (int k = 0; k < 4; k++) begin
            e = '0;
            if (k < n) e = mupd(mq[k], wd, kill);
            chk($sformatf("mdl_inst%0d", k + 1), 32'(obs_inst[k]), 32'(e));
        end
        pop  = en && qr;
        push = v && (n < DEPTH);
        foreach (mq[i]) mq[i] = mupd(mq[i], wd, kill);
        if (pop)
            for (int i = 0; i < (n < 4 ? n : 4); i++) void'(mq.pop_front());
        if (push) mq.push_back(mupd(inst, wd, kill));
        if (push || pop) mt = 0;
        else if (n > 0 && n < 4 && mt < TIMEOUT) mt++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic qr);
        step(1'b0, '0, '0, '0, qr);
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.i_valid   = 1'b1;
        bus.i_inst    = pu(99);
        bus.i_wdest4x = '0;
        bus.i_BrKill  = '0;
        bus.i_qready  = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        mq.delete();
        mt = 0;
    endtask

    vec_t         tbl [14];
    logic [W-1:0] ua, ub, uc, ud, ue, uf, z, u, ukw;
    logic [31:0]  r;
    logic [11:0]  wd;
    logic [2:0]   kl;

    initial begin
        z  = '0;
        ua = mk(7'h11, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 1'b1, 1'b0, 1'b1);
        ub = mk(7'h22, 3'd2, 3'd2, 3'd3, 3'd4, 3'd5, 1'b1, 1'b1, 1'b0);
        uc = mk(7'h33, 3'd4, 3'd3, 3'd4, 3'd5, 3'd6, 1'b1, 1'b0, 1'b0);
        ud = mk(7'h44, 3'd0, 3'd4, 3'd5, 3'd6, 3'd7, 1'b1, 1'b1, 1'b1);
        ue = mk(7'h55, 3'd1, 3'd5, 3'd6, 3'd7, 3'd1, 1'b1, 1'b0, 1'b0);
        uf = mk(7'h66, 3'd2, 3'd6, 3'd7, 3'd1, 3'd2, 1'b0, 1'b0, 1'b0);

        tbl[0]  = row(1'b1, ua, 1'b1, 1'b0, 0, z,  z);
        tbl[1]  = row(1'b1, ub, 1'b1, 1'b0, 1, ua, z);
        tbl[2]  = row(1'b1, uc, 1'b1, 1'b0, 2, ua, z);
        tbl[3]  = row(1'b1, ud, 1'b1, 1'b0, 3, ua, z);
        tbl[4]  = row(1'b0, z,  1'b1, 1'b1, 4, ua, ud);
        tbl[5]  = row(1'b0, z,  1'b1, 1'b0, 0, z,  z);
        tbl[6]  = row(1'b1, ue, 1'b1, 1'b0, 0, z,  z);
        tbl[7]  = row(1'b1, uf, 1'b1, 1'b0, 1, ue, z);
        tbl[8]  = row(1'b0, z,  1'b1, 1'b0, 2, ue, z);
        tbl[9]  = row(1'b0, z,  1'b1, 1'b0, 2, ue, z);
        tbl[10] = row(1'b0, z,  1'b1, 1'b0, 2, ue, z);
        tbl[11] = row(1'b0, z,  1'b1, 1'b0, 2, ue, z);
        tbl[12] = row(1'b0, z,  1'b1, 1'b1, 2, ue, z);
        tbl[13] = row(1'b0, z,  1'b1, 1'b0, 0, z,  z);

        bus.i_valid = 1'b0; bus.i_inst = '0; bus.i_wdest4x = '0;
        bus.i_BrKill = '0; bus.i_qready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Full bundle, then partial flush on timeout.
        for (int i = 0; i < 14; i++) begin
            step(tbl[i].v, tbl[i].inst, '0, '0, tbl[i].qr);
            chk($sformatf("tbl%0d_en", i), 32'(obs_en), 32'(tbl[i].en));
            chk($sformatf("tbl%0d_cnt", i), 32'(obs_cnt), 32'(tbl[i].cnt));
            chk($sformatf("tbl%0d_i1", i), 32'(obs_inst[0]), 32'(tbl[i].i1));
            chk($sformatf("tbl%0d_i4", i), 32'(obs_inst[3]), 32'(tbl[i].i4));
        end

        // Backpressure until full; the ninth push is dropped.
        do_reset();
        for (int i = 1; i <= 9; i++) step(1'b1, pu(i), '0, '0, 1'b0);
        chk("full_ready", 32'(obs_ready), 32'd0);
        chk("full_cnt", 32'(obs_cnt), 32'd8);
        idle(1'b1);
        chk("bp_b1_en", 32'(obs_en), 32'd1);
        for (int k = 0; k < 4; k++)
            chk($sformatf("bp_b1_i%0d", k + 1), 32'(obs_inst[k]), 32'(pu(k + 1)));
        idle(1'b1);
        chk("bp_b2_cnt", 32'(obs_cnt), 32'd4);
        for (int k = 0; k < 4; k++)
            chk($sformatf("bp_b2_i%0d", k + 1), 32'(obs_inst[k]), 32'(pu(k + 5)));
        idle(1'b1);
        chk("bp_empty", 32'(obs_cnt), 32'd0);

        // Wakeup and kill on a buffered uop.
        do_reset();
        u   = mk(7'h2A, 3'b011, 3'd5, 3'd7, 3'd1, 3'd6, 1'b1, 1'b0, 1'b0);
        ukw = mk(7'h2A, 3'b011, 3'd5, 3'd7, 3'd1, 3'd6, 1'b0, 1'b0, 1'b1);
        step(1'b1, u, '0, '0, 1'b0);
        step(1'b0, '0, {3'b110, 3'd0, 3'd0, 3'd0}, 3'b010, 1'b0);
        chk("wk_comb", 32'(obs_inst[0]), 32'(ukw));
        idle(1'b0);
        chk("wk_stored", 32'(obs_inst[0]), 32'(ukw));

        // Bundle straddling the wrap, with a push in the pop cycle.
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b1, pu(20 + i), '0, '0, 1'b0);
        idle(1'b1);
        repeat (5) idle(1'b1);
        chk("wrap_empty", 32'(obs_cnt), 32'd2);
        for (int i = 0; i < 4; i++) step(1'b1, pu(40 + i), '0, '0, 1'b0);
        step(1'b1, pu(44), '0, '0, 1'b1);
        chk("wrap_en", 32'(obs_en), 32'd1);
        for (int k = 0; k < 4; k++)
            chk($sformatf("wrap_i%0d", k + 1), 32'(obs_inst[k]), 32'(pu(40 + k)));
        idle(1'b0);
        chk("pushpop_cnt", 32'(obs_cnt), 32'd1);
        chk("pushpop_i1", 32'(obs_inst[0]), 32'(pu(44)));

        // Random traffic against the queue model.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            r  = $urandom;
            wd = 12'($urandom);
            kl = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'd0;
            step($urandom_range(0, 3) != 0, r[W-1:0], wd, kl,
                 $urandom_range(0, 3) != 0);
        end

        // Reset mid-stream.
        for (int i = 0; i < 3; i++) step(1'b1, pu(60 + i), '0, '0, 1'b0);
        do_reset();
        idle(1'b0);
        chk("rst_cnt", 32'(obs_cnt), 32'd0);
        chk("rst_en", 32'(obs_en), 32'd0);
        chk("rst_ready", 32'(obs_ready), 32'd1);
        for (int k = 0; k < 4; k++)
            chk($sformatf("rst_i%0d", k + 1), 32'(obs_inst[k]), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
